// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and architectural register file.
//
// Picks the writeback value from the registered MEM/WB fields, writes it into
// the register file, serves the two decode-stage read ports, exposes the
// current writeback to the forwarding unit and counts writeback commits.
//
// Build option:
//   WB_BYPASS_EN  defined   -> a read of the index being written this cycle
//                              returns the value being written (write-through).
//                 undefined -> reads return the contents held before the edge.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   wb_alu_out_in      ALU result
//   wb_mem_data_in     load data
//   wb_pc_imm_in       PC + immediate
//   wb_imm_in          immediate (LUI)
//   wb_rd_in           destination index
//   wb_reg_in_sel_in   source select: 00 alu, 01 pc_imm, 10 imm, 11 alu
//   wb_mem_reg_in      1 = load data, overrides the select
//   wb_reg_wr_in       register write enable
//   rs1_addr/rs2_addr  read indices
//   rs1_data/rs2_data  read data (index 0 reads 0)
//   fwd_wr/rd/data     current writeback for the forwarding unit
//   commit_cnt         edges seen with wb_reg_wr_in = 1 (rd = 0 included)

module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  wb_alu_out_in,
    input  logic [XLEN-1:0]  wb_mem_data_in,
    input  logic [XLEN-1:0]  wb_pc_imm_in,
    input  logic [XLEN-1:0]  wb_imm_in,
    input  logic [4:0]       wb_rd_in,
    input  logic [1:0]       wb_reg_in_sel_in,
    input  logic             wb_mem_reg_in,
    input  logic             wb_reg_wr_in,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             fwd_wr,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] commit_cnt
);

    localparam int IDX_W = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] wb_data;

    always_comb begin
        wb_data = wb_alu_out_in;
        if (wb_mem_reg_in) begin
            wb_data = wb_mem_data_in;
        end else begin
            case (wb_reg_in_sel_in)
                2'b01:   wb_data = wb_pc_imm_in;
                2'b10:   wb_data = wb_imm_in;
                default: wb_data = wb_alu_out_in;
            endcase
        end
    end

    // rd = 0 never asserts fwd_wr, so x0 is never written and stays at its
    // reset value of zero.
    assign fwd_wr   = wb_reg_wr_in && (wb_rd_in != 5'd0);
    assign fwd_rd   = wb_rd_in;
    assign fwd_data = wb_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            commit_cnt <= '0;
        end else begin
            if (fwd_wr) begin
                regs[wb_rd_in[IDX_W-1:0]] <= wb_data;
            end
            if (wb_reg_wr_in) begin
                commit_cnt <= commit_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != 5'd0) begin
            rs1_data = regs[rs1_addr[IDX_W-1:0]];
        end
        if (rs2_addr != 5'd0) begin
            rs2_data = regs[rs2_addr[IDX_W-1:0]];
        end
`ifdef WB_BYPASS_EN
        // fwd_wr already excludes rd = 0, so x0 still reads zero.
        if (fwd_wr && (rs1_addr == wb_rd_in)) begin
            rs1_data = wb_data;
        end
        if (fwd_wr && (rs2_addr == wb_rd_in)) begin
            rs2_data = wb_data;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_alu_out_in, wb_mem_data_in, wb_pc_imm_in, wb_imm_in;
    logic [4:0]  wb_rd_in;
    logic [1:0]  wb_reg_in_sel_in;
    logic        wb_mem_reg_in, wb_reg_wr_in;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, fwd_data, commit_cnt;
    logic        fwd_wr;
    logic [4:0]  fwd_rd;

    // Narrow-counter copy so the wrap can be reached in a few cycles.
    logic [31:0] w_rs1_data, w_rs2_data, w_fwd_data;
    logic        w_fwd_wr;
    logic [4:0]  w_fwd_rd;
    logic [2:0]  w_commit_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset),
        .wb_alu_out_in(wb_alu_out_in), .wb_mem_data_in(wb_mem_data_in),
        .wb_pc_imm_in(wb_pc_imm_in), .wb_imm_in(wb_imm_in),
        .wb_rd_in(wb_rd_in), .wb_reg_in_sel_in(wb_reg_in_sel_in),
        .wb_mem_reg_in(wb_mem_reg_in), .wb_reg_wr_in(wb_reg_wr_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_wr(fwd_wr), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .commit_cnt(commit_cnt)
    );

    wb_regfile #(.CNT_W(3)) u_wrap (
        .clk(clk), .reset(reset),
        .wb_alu_out_in(wb_alu_out_in), .wb_mem_data_in(wb_mem_data_in),
        .wb_pc_imm_in(wb_pc_imm_in), .wb_imm_in(wb_imm_in),
        .wb_rd_in(wb_rd_in), .wb_reg_in_sel_in(wb_reg_in_sel_in),
        .wb_mem_reg_in(wb_mem_reg_in), .wb_reg_wr_in(wb_reg_wr_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(w_rs1_data), .rs2_data(w_rs2_data),
        .fwd_wr(w_fwd_wr), .fwd_rd(w_fwd_rd), .fwd_data(w_fwd_data),
        .commit_cnt(w_commit_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        wb_alu_out_in = '0; wb_mem_data_in = '0; wb_pc_imm_in = '0; wb_imm_in = '0;
        wb_rd_in = '0; wb_reg_in_sel_in = '0; wb_mem_reg_in = 1'b0; wb_reg_wr_in = 1'b0;
        rs1_addr = '0; rs2_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_cnt", commit_cnt, 32'd0);
        check("reset_fwd_wr", {31'd0, fwd_wr}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check("reset_rs1", rs1_data, 32'd0);
            check("reset_rs2", rs2_data, 32'd0);
        end

        // ALU write to x5
        wb_reg_wr_in = 1'b1; wb_rd_in = 5'd5; wb_reg_in_sel_in = 2'b00;
        wb_alu_out_in = 32'hDEADBEEF; rs1_addr = 5'd5;
        #1;
        check("x5_fwd_wr", {31'd0, fwd_wr}, 32'd1);
        check("x5_fwd_rd", {27'd0, fwd_rd}, 32'd5);
        check("x5_fwd_data", fwd_data, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
        check("x5_pre_edge", rs1_data, 32'hDEADBEEF);
`else
        check("x5_pre_edge", rs1_data, 32'd0);
`endif
        tick();
        wb_reg_wr_in = 1'b0;
        #1;
        check("x5_read", rs1_data, 32'hDEADBEEF);
        check("cnt_1", commit_cnt, 32'd1);

        // source priority
        wb_reg_wr_in = 1'b1;
        wb_mem_reg_in = 1'b1; wb_reg_in_sel_in = 2'b01; wb_mem_data_in = 32'h12345678;
        wb_pc_imm_in = 32'h00001000; wb_imm_in = 32'hABCD0000; wb_alu_out_in = 32'h0BADF00D;
        wb_rd_in = 5'd7;
        #1;
        check("mem_over_sel", fwd_data, 32'h12345678);
        tick();
        wb_mem_reg_in = 1'b0; wb_reg_in_sel_in = 2'b10; wb_rd_in = 5'd8;
        #1;
        check("sel_imm", fwd_data, 32'hABCD0000);
        tick();
        wb_reg_in_sel_in = 2'b11; wb_rd_in = 5'd10;
        #1;
        check("sel_rsvd_alu", fwd_data, 32'h0BADF00D);
        tick();
        wb_reg_in_sel_in = 2'b01; wb_rd_in = 5'd11;
        #1;
        check("sel_pc_imm", fwd_data, 32'h00001000);
        tick();
        wb_reg_wr_in = 1'b0;
        rs1_addr = 5'd7; rs2_addr = 5'd8;
        #1;
        check("x7_read", rs1_data, 32'h12345678);
        check("x8_read", rs2_data, 32'hABCD0000);
        rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        check("x10_read", rs1_data, 32'h0BADF00D);
        check("x11_read", rs2_data, 32'h00001000);
        check("cnt_5", commit_cnt, 32'd5);

        // write enable low: no write, no count
        wb_reg_in_sel_in = 2'b00; wb_rd_in = 5'd12; wb_alu_out_in = 32'h00000099;
        rs1_addr = 5'd12;
        #1;
        check("nowr_fwd_wr", {31'd0, fwd_wr}, 32'd0);
        tick();
        check("nowr_x12", rs1_data, 32'd0);
        check("nowr_cnt", commit_cnt, 32'd5);

        // write to x0: discarded but counted
        wb_reg_wr_in = 1'b1; wb_rd_in = 5'd0; wb_alu_out_in = 32'hFFFFFFFF; rs1_addr = 5'd0;
        #1;
        check("x0_fwd_wr", {31'd0, fwd_wr}, 32'd0);
        check("x0_fwd_data", fwd_data, 32'hFFFFFFFF);
        check("x0_pre_edge", rs1_data, 32'd0);
        tick();
        wb_reg_wr_in = 1'b0;
        #1;
        check("x0_read", rs1_data, 32'd0);
        check("cnt_6", commit_cnt, 32'd6);

        // same-cycle read/write of x3
        wb_reg_wr_in = 1'b1; wb_rd_in = 5'd3; wb_alu_out_in = 32'h00000011;
        tick();
        wb_alu_out_in = 32'h00000055; rs2_addr = 5'd3;
        #1;
`ifdef WB_BYPASS_EN
        check("x3_same_cycle", rs2_data, 32'h00000055);
`else
        check("x3_same_cycle", rs2_data, 32'h00000011);
`endif
        tick();
        wb_reg_wr_in = 1'b0;
        #1;
        check("x3_next_cycle", rs2_data, 32'h00000055);
        check("cnt_8", commit_cnt, 32'd8);

        // reset with a simultaneous write
        reset = 1'b1;
        wb_reg_wr_in = 1'b1; wb_rd_in = 5'd9; wb_alu_out_in = 32'h00000077;
        rs1_addr = 5'd9; rs2_addr = 5'd5;
        tick();
        reset = 1'b0; wb_reg_wr_in = 1'b0;
        #1;
        check("rst_x9", rs1_data, 32'd0);
        check("rst_x5", rs2_data, 32'd0);
        check("rst_cnt", commit_cnt, 32'd0);
        check("rst_wrap_cnt", {29'd0, w_commit_cnt}, 32'd0);

        // first write after reset lands
        wb_reg_wr_in = 1'b1;
        tick();
        wb_reg_wr_in = 1'b0;
        #1;
        check("post_rst_x9", rs1_data, 32'h00000077);
        check("post_rst_cnt", commit_cnt, 32'd1);

        // counter wrap on the 3-bit instance: 1 -> 7 -> 0
        wb_reg_wr_in = 1'b1; wb_rd_in = 5'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("wrap_at_max", {29'd0, w_commit_cnt}, 32'd7);
        tick();
        wb_reg_wr_in = 1'b0;
        #1;
        check("wrap_to_zero", {29'd0, w_commit_cnt}, 32'd0);
        check("cnt_no_wrap", commit_cnt, 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
